// File: rtl/qpi_responder_pkg.sv
// Shared definitions for the QPI link-layer responder: FSM encoding and the
// byte substituted when the decoder has nothing ready at a transmit slot.
package qpi_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RX   = 2'd1,
        ST_TURN = 2'd2,
        ST_TX   = 2'd3
    } qpi_state_e;

    localparam logic [7:0] UNDERRUN_FILL = 8'h00;

endpackage

// File: rtl/qpi_responder_sync_filter.sv
// Two-flop synchroniser followed by a stability filter. The filtered level
// only flips after FILTER_LEN consecutive synchronised samples disagree with
// it, so pulses shorter than FILTER_LEN clock cycles never get through.
// change_o is a combinational one-cycle pulse in the cycle the flip is
// accepted; level_o still shows the old level during that cycle.
module qpi_sync_filter #(
    parameter int   FILTER_LEN = 2,
    parameter logic RESET_VAL  = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din_i,
    output logic level_o,
    output logic change_o
);

    logic [1:0]            sync_q;
    logic [FILTER_LEN-1:0] hist_q;
    logic                  level_q;
    logic                  all_hi;
    logic                  all_lo;

    assign all_hi   = &hist_q;
    assign all_lo   = ~|hist_q;
    assign change_o = level_q ? all_lo : all_hi;
    assign level_o  = level_q;

    // Synchronise, record the last FILTER_LEN samples, accept stable changes.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= {2{RESET_VAL}};
            hist_q  <= {FILTER_LEN{RESET_VAL}};
            level_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[0], din_i};
            hist_q <= (hist_q << 1) | FILTER_LEN'(sync_q[1]);
            if (change_o) begin
                level_q <= ~level_q;
            end
        end
    end

endmodule

// File: rtl/qpi_responder.sv
// Device end of the 4-bit QPI host link. Oversamples the host clock and chip
// select, assembles received nibbles into bytes, and in read phases shifts
// decoder bytes back out, owning the pad output enable.
//
// Transmit handshake: at every transmit byte-slot boundary the block samples
// tx_valid once. If high, tx_data is captured and tx_ready pulses for one
// cycle (the byte is consumed); if low, the fill byte is sent instead and
// tx_underrun pulses. tx_valid/tx_data are not looked at between boundaries.
module qpi_responder
    import qpi_responder_pkg::*;
#(
    parameter int FILTER_LEN = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       qpi_csb,
    input  logic       qpi_clk,
    input  logic [3:0] io_din,
    output logic [3:0] io_dout,
    output logic       io_oe,
    output logic       rx_start,
    output logic       rx_stop,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       tx_mode,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_underrun,
    output qpi_state_e dbg_state
);

    // Data delay matches synchroniser (2) plus filter (FILTER_LEN) latency so
    // the nibble sampled with an edge event is the one present at the pad edge.
    localparam int DLY = 2 + FILTER_LEN;

    logic clk_lvl, clk_chg, csb_lvl, csb_chg;
    logic pos, neg, csb_fall, csb_rise;
    logic [3:0] din_dly;
    logic [7:0] next_byte;

    logic [DLY-1:0][3:0] din_pipe_q;
    qpi_state_e state_q, state_d;
    logic       phase_q, phase_d;
    logic [3:0] hi_q, hi_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_start_q, rx_start_d;
    logic       rx_stop_q, rx_stop_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       tx_ready_q, tx_ready_d;
    logic       tx_under_q, tx_under_d;
    logic       oe_q, oe_d;
    logic [3:0] dout_q, dout_d;

    qpi_sync_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b0)) u_clk_filt (
        .clock(clock), .reset(reset), .din_i(qpi_clk),
        .level_o(clk_lvl), .change_o(clk_chg)
    );

    qpi_sync_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b1)) u_csb_filt (
        .clock(clock), .reset(reset), .din_i(qpi_csb),
        .level_o(csb_lvl), .change_o(csb_chg)
    );

    // Clock edges only count while the filtered chip select is low.
    assign pos      = clk_chg & ~clk_lvl & ~csb_lvl;
    assign neg      = clk_chg &  clk_lvl & ~csb_lvl;
    assign csb_fall = csb_chg &  csb_lvl;
    assign csb_rise = csb_chg & ~csb_lvl;
    assign din_dly  = din_pipe_q[DLY-1];
    assign next_byte = tx_valid ? tx_data : UNDERRUN_FILL;

    // Pad data delay line.
    always_ff @(posedge clock) begin
        if (reset) begin
            din_pipe_q <= '0;
        end else begin
            din_pipe_q <= {din_pipe_q[DLY-2:0], io_din};
        end
    end

    // Next-state and output logic; a chip-select rise overrides every event.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        hi_d       = hi_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_start_d = 1'b0;
        rx_stop_d  = 1'b0;
        tx_byte_d  = tx_byte_q;
        tx_ready_d = 1'b0;
        tx_under_d = 1'b0;
        oe_d       = oe_q;
        dout_d     = dout_q;
        if (csb_rise) begin
            state_d   = ST_IDLE;
            phase_d   = 1'b0;
            oe_d      = 1'b0;
            rx_stop_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (csb_fall) begin
                        state_d    = ST_RX;
                        phase_d    = 1'b0;
                        rx_start_d = 1'b1;
                    end
                end
                ST_RX: begin
                    if (pos) begin
                        if (!phase_q) begin
                            hi_d    = din_dly;
                            phase_d = 1'b1;
                        end else begin
                            rx_data_d  = {hi_q, din_dly};
                            rx_valid_d = 1'b1;
                            phase_d    = 1'b0;
                            if (tx_mode) state_d = ST_TURN;
                        end
                    end
                end
                ST_TURN: begin
                    if (pos) begin
                        if (!phase_q) begin
                            phase_d = 1'b1;
                        end else begin
                            phase_d    = 1'b0;
                            tx_byte_d  = next_byte;
                            tx_ready_d = tx_valid;
                            tx_under_d = ~tx_valid;
                            state_d    = ST_TX;
                        end
                    end
                end
                ST_TX: begin
                    if (neg) begin
                        oe_d   = 1'b1;
                        dout_d = phase_q ? tx_byte_q[3:0] : tx_byte_q[7:4];
                    end
                    if (pos) begin
                        if (!phase_q) begin
                            phase_d = 1'b1;
                        end else begin
                            phase_d    = 1'b0;
                            tx_byte_d  = next_byte;
                            tx_ready_d = tx_valid;
                            tx_under_d = ~tx_valid;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            phase_q    <= 1'b0;
            hi_q       <= 4'h0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_start_q <= 1'b0;
            rx_stop_q  <= 1'b0;
            tx_byte_q  <= 8'h00;
            tx_ready_q <= 1'b0;
            tx_under_q <= 1'b0;
            oe_q       <= 1'b0;
            dout_q     <= 4'h0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            hi_q       <= hi_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_start_q <= rx_start_d;
            rx_stop_q  <= rx_stop_d;
            tx_byte_q  <= tx_byte_d;
            tx_ready_q <= tx_ready_d;
            tx_under_q <= tx_under_d;
            oe_q       <= oe_d;
            dout_q     <= dout_d;
        end
    end

    assign io_dout     = dout_q;
    assign io_oe       = oe_q;
    assign rx_start    = rx_start_q;
    assign rx_stop     = rx_stop_q;
    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign tx_ready    = tx_ready_q;
    assign tx_underrun = tx_under_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_qpi_responder.sv
// Directed bench for qpi_responder: acts as the QPI host on the pads and as
// the command decoder on the tx side.
module tb_qpi_responder;
    import qpi_responder_pkg::*;

    localparam int FL = 2;
    localparam int PH = 8;   // host clock phase in system clocks (>= FL + 4)

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       qpi_csb = 1'b1;
    logic       qpi_clk = 1'b0;
    logic [3:0] io_din = 4'h0;
    logic [3:0] io_dout;
    logic       io_oe;
    logic       rx_start, rx_stop, rx_valid;
    logic [7:0] rx_data;
    logic       tx_mode = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_underrun;
    qpi_state_e dbg_state;

    int n_cmp = 0;
    int n_mis = 0;

    int cnt_start = 0, cnt_stop = 0, cnt_valid = 0;
    int cnt_ready = 0, cnt_under = 0, cnt_oe = 0;
    logic [7:0] rx_got[$];

    qpi_responder #(.FILTER_LEN(FL)) dut (
        .clock(clock), .reset(reset), .qpi_csb(qpi_csb), .qpi_clk(qpi_clk),
        .io_din(io_din), .io_dout(io_dout), .io_oe(io_oe),
        .rx_start(rx_start), .rx_stop(rx_stop), .rx_valid(rx_valid),
        .rx_data(rx_data), .tx_mode(tx_mode), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .tx_underrun(tx_underrun),
        .dbg_state(dbg_state)
    );

    // Clock generation.
    always #5 clock = ~clock;

    // Output monitor: counts pulses and collects received bytes.
    always @(negedge clock) begin
        if (!reset) begin
            if (rx_start)    cnt_start++;
            if (rx_stop)     cnt_stop++;
            if (tx_ready)    cnt_ready++;
            if (tx_underrun) cnt_under++;
            if (io_oe)       cnt_oe++;
            if (rx_valid) begin
                cnt_valid++;
                rx_got.push_back(rx_data);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pop_rx();
        if (rx_got.size() == 0) return 8'hxx;
        return rx_got.pop_front();
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic host_nibble(input logic [3:0] n);
        qpi_clk = 1'b0;
        io_din  = n;
        wait_cyc(PH);
        qpi_clk = 1'b1;
        wait_cyc(PH);
    endtask

    task automatic host_send(input logic [7:0] b);
        host_nibble(b[7:4]);
        host_nibble(b[3:0]);
    endtask

    // Wait byte: two clocks with the pad drivers required to stay off.
    task automatic host_dummy();
        for (int i = 0; i < 2; i++) begin
            qpi_clk = 1'b0;
            wait_cyc(PH);
            chk("turn_oe_off", io_oe, 1'b0);
            qpi_clk = 1'b1;
            wait_cyc(PH);
        end
    endtask

    task automatic host_recv(output logic [7:0] b);
        for (int i = 0; i < 2; i++) begin
            qpi_clk = 1'b0;
            wait_cyc(PH);
            chk("tx_oe_on", io_oe, 1'b1);
            b = {b[3:0], io_dout};
            qpi_clk = 1'b1;
            wait_cyc(PH);
        end
    endtask

    task automatic csb_low();
        qpi_clk = 1'b0;
        qpi_csb = 1'b0;
        wait_cyc(PH);
    endtask

    task automatic csb_high();
        qpi_clk = 1'b0;
        wait_cyc(PH);
        qpi_csb = 1'b1;
        wait_cyc(PH);
    endtask

    initial begin
        int s_start, s_stop, s_valid, s_ready, s_under, s_oe;
        logic [7:0] b;
        bit seen;

        // Reset
        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(1);
        chk("reset_oe", io_oe, 1'b0);
        chk("reset_dout", io_dout, 4'h0);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_pulses", {rx_start, rx_stop, rx_valid, tx_ready, tx_underrun}, 5'b0);
        chk("reset_state", dbg_state, ST_IDLE);
        wait_cyc(4);

        // Write transaction
        s_start = cnt_start; s_stop = cnt_stop; s_valid = cnt_valid; s_oe = cnt_oe;
        rx_got.delete();
        csb_low();
        host_send(8'h21);
        host_send(8'hA5);
        host_send(8'h3C);
        csb_high();
        chk("wr_start", cnt_start - s_start, 1);
        chk("wr_valid", cnt_valid - s_valid, 3);
        chk("wr_byte0", pop_rx(), 8'h21);
        chk("wr_byte1", pop_rx(), 8'hA5);
        chk("wr_byte2", pop_rx(), 8'h3C);
        chk("wr_stop", cnt_stop - s_stop, 1);
        chk("wr_oe_never", cnt_oe - s_oe, 0);

        // Read transaction
        s_ready = cnt_ready;
        rx_got.delete();
        tx_mode = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A;
        csb_low();
        host_send(8'h22);
        chk("rd_cmd", pop_rx(), 8'h22);
        host_dummy();
        chk("rd_state_tx", dbg_state, ST_TX);
        tx_data = 8'h00;
        host_recv(b);
        chk("rd_byte0", b, 8'h5A);
        tx_valid = 1'b0;
        host_recv(b);
        chk("rd_byte1", b, 8'h00);
        csb_high();
        chk("rd_ready", cnt_ready - s_ready, 2);
        chk("rd_oe_idle", io_oe, 1'b0);
        tx_mode = 1'b0;

        // Underrun at the first transmit latch
        s_under = cnt_under; s_ready = cnt_ready;
        tx_mode = 1'b1; tx_valid = 1'b0; tx_data = 8'hEE;
        csb_low();
        host_send(8'h22);
        host_dummy();
        chk("ur_under_once", cnt_under - s_under, 1);
        tx_valid = 1'b1; tx_data = 8'h77;
        host_recv(b);
        chk("ur_byte0", b, 8'h00);
        host_recv(b);
        chk("ur_byte1", b, 8'h77);
        csb_high();
        chk("ur_under_total", cnt_under - s_under, 1);
        chk("ur_ready", cnt_ready - s_ready, 2);
        tx_mode = 1'b0; tx_valid = 1'b0;

        // Clock glitch just after a rising edge
        s_valid = cnt_valid;
        rx_got.delete();
        csb_low();
        qpi_clk = 1'b0; io_din = 4'h2;
        wait_cyc(PH);
        qpi_clk = 1'b1;
        wait_cyc(1);
        qpi_clk = 1'b0;
        wait_cyc(1);
        qpi_clk = 1'b1;
        wait_cyc(PH);
        host_nibble(4'h3);
        csb_high();
        chk("gl_valid", cnt_valid - s_valid, 1);
        chk("gl_byte", pop_rx(), 8'h23);

        // Abort after one nibble, then a clean byte
        s_valid = cnt_valid;
        rx_got.delete();
        csb_low();
        host_nibble(4'hF);
        csb_high();
        chk("ab1_no_valid", cnt_valid - s_valid, 0);
        csb_low();
        host_send(8'h96);
        csb_high();
        chk("ab1_next_valid", cnt_valid - s_valid, 1);
        chk("ab1_next_byte", pop_rx(), 8'h96);

        // Abort in the middle of a transmit byte
        rx_got.delete();
        tx_mode = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A;
        csb_low();
        host_send(8'h22);
        host_dummy();
        s_valid = cnt_valid;
        qpi_clk = 1'b0;
        wait_cyc(PH);
        chk("ab2_oe_on", io_oe, 1'b1);
        chk("ab2_hi_nib", io_dout, 4'h5);
        qpi_csb = 1'b1;
        seen = 1'b0;
        for (int i = 1; i <= 2 + FL + 1; i++) begin
            @(negedge clock);
            if (!io_oe) begin
                seen = 1'b1;
                break;
            end
        end
        chk("ab2_oe_off_bound", seen, 1'b1);
        wait_cyc(PH);
        tx_mode = 1'b0; tx_valid = 1'b0;
        chk("ab2_no_valid", cnt_valid - s_valid, 0);
        rx_got.delete();
        csb_low();
        host_send(8'hC3);
        csb_high();
        chk("ab2_next_byte", pop_rx(), 8'hC3);

        // Reset during transmit
        tx_mode = 1'b1; tx_valid = 1'b1; tx_data = 8'hB4;
        csb_low();
        host_send(8'h22);
        host_dummy();
        qpi_clk = 1'b0;
        wait_cyc(PH);
        chk("rs_oe_before", io_oe, 1'b1);
        reset = 1'b1;
        wait_cyc(1);
        chk("rs_oe", io_oe, 1'b0);
        chk("rs_dout", io_dout, 4'h0);
        chk("rs_rx_data", rx_data, 8'h00);
        chk("rs_pulses", {rx_start, rx_stop, rx_valid, tx_ready, tx_underrun}, 5'b0);
        chk("rs_state", dbg_state, ST_IDLE);
        tx_mode = 1'b0; tx_valid = 1'b0;
        qpi_csb = 1'b1; qpi_clk = 1'b0;
        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(4);
        s_valid = cnt_valid;
        rx_got.delete();
        csb_low();
        host_send(8'h20);
        csb_high();
        chk("rs_next_valid", cnt_valid - s_valid, 1);
        chk("rs_next_byte", pop_rx(), 8'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
